// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: round-robin owner of the LC-3 memory/IO bus for CPU (port 0) and DMA (port 1).
// Each grant drives MIO_EN for WAIT_CYCLES+1 cycles, then pulses the winner's ready.
module mio_bus_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_r_w,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        cpu_r,
    input  logic        dma_req,
    input  logic        dma_r_w,
    input  logic [15:0] dma_addr,
    input  logic [15:0] dma_wdata,
    output logic        dma_r,
    output logic [15:0] rdata,
    output logic [15:0] mar,
    output logic [15:0] mdr_out,
    output logic        r_w,
    output logic        mio_en,
    input  logic [15:0] bus_rdata,
    output logic        busy,
    output logic        gnt_id
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t     state, next;
    logic [3:0] wait_cnt;
    logic       last_gnt;
    logic       any_req;
    logic       pick;
    assign any_req = cpu_req | dma_req;
    // On a tie the port that did not win last time goes next
    assign pick = (cpu_req & dma_req) ? ~last_gnt : dma_req;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;
    always_comb begin
        next   = state;
        mio_en = 1'b0;
        busy   = 1'b0;
        cpu_r  = 1'b0;
        dma_r  = 1'b0;
        next   = state == IDLE   ? (any_req ? ACCESS : IDLE) :
                 state == ACCESS ? (wait_cnt == 4'd0 ? DONE : ACCESS) : IDLE;
        mio_en = state == ACCESS;
        busy   = state != IDLE;
        cpu_r  = state == DONE && !gnt_id;
        dma_r  = state == DONE && gnt_id;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mar      <= 16'h0000;
            mdr_out  <= 16'h0000;
            r_w      <= 1'b0;
            rdata    <= 16'h0000;
            gnt_id   <= 1'b0;
            last_gnt <= 1'b1;
            wait_cnt <= 4'd0;
        end else begin
            if (state == IDLE && any_req) begin
                mar      <= pick ? dma_addr  : cpu_addr;
                mdr_out  <= pick ? dma_wdata : cpu_wdata;
                r_w      <= pick ? dma_r_w   : cpu_r_w;
                gnt_id   <= pick;
                last_gnt <= pick;
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if (state == ACCESS && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (state == ACCESS && wait_cnt == 4'd0 && !r_w) rdata <= bus_rdata;
        end
endmodule
